// File: rtl/arilla_seq_pkg.sv
// ============================================================================
//  Module      : arilla_seq_pkg
//  Description : Shared definitions for the Arilla transmit sequencer:
//                register offsets inside the transceiver bank, CSR bit
//                positions, the sequencer state encoding and a helper that
//                builds CSR write words.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package arilla_seq_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [31:0] CSR_OFS  = 32'h0000_0000;
  localparam logic [31:0] BTR_OFS  = 32'h0000_0004;
  localparam logic [31:0] FIFO_OFS = 32'h0000_0008;

  // CSR bit positions
  localparam int CSR_RECV_NE  = 0;
  localparam int CSR_RECV_F   = 1;
  localparam int CSR_SEND_NE  = 2;
  localparam int CSR_SEND_F   = 3;
  localparam int CSR_RECV_EN  = 4;
  localparam int CSR_START    = 5;
  localparam int CSR_TRANS_IP = 6;
  localparam int CSR_CTRL_LSB = 7;   // LOOP/INV/SOUND_SAMP/SOUND_EN at 10:7

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CFG_BTR   = 4'd1,
    ST_CFG_CSR   = 4'd2,
    ST_POLL_SEND = 4'd3,
    ST_PUSH      = 4'd4,
    ST_START     = 4'd5,
    ST_GAP       = 4'd6,
    ST_POLL_TIP  = 4'd7,
    ST_RX_READ   = 4'd8,
    ST_DONE      = 4'd9
  } seq_state_e;

  // ctrl = {LOOP, INV, SOUND_SAMP, SOUND_EN, RECV_EN}; the upper four land
  // on CSR[10:7], RECV_EN on CSR[4].
  function automatic logic [31:0] csr_word(input logic [4:0] ctrl, input logic start);
    logic [31:0] w;
    w = '0;
    w[CSR_CTRL_LSB +: 4] = ctrl[4:1];
    w[CSR_RECV_EN]       = ctrl[0];
    w[CSR_START]         = start;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arilla_tx_sequencer.sv
// ============================================================================
//  Module      : arilla_tx_sequencer
//  Description : Bus master that drives the Arilla serial transceiver register
//                bank. Optionally reloads the bit time, configures CSR, fills
//                the send FIFO while polling SEND_F, fires START and waits for
//                TRANS_IP to clear; repeats per FIFO-sized chunk until the
//                command length is consumed.
//  Build option: ARILLA_SEQ_RX_DRAIN_EN - drain the receive FIFO while
//                waiting for TRANS_IP and present the bytes on rx_valid/rx_data.
//  Ports       :
//    clk, rst                   clock, asynchronous active-high reset
//    cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//    cmd_len, cmd_ctrl          byte count, {LOOP,INV,SOUND_SAMP,SOUND_EN,RECV_EN}
//    cmd_btr, cmd_btr_wr        bit time value and reload enable
//    tx_valid/tx_ready, tx_data byte stream into the send FIFO
//    busy, done                 activity flag, one-cycle completion pulse
//    bus_addr/bus_wdata         bus address / write data (0 when idle)
//    bus_rd/bus_wr, bus_rdata   single-cycle strobes, combinational read data
//    rx_valid, rx_data          drained receive bytes (build option only)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module arilla_tx_sequencer
  import arilla_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LEN_W     = 8,
  parameter int          START_GAP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [4:0]       cmd_ctrl,
  input  logic [31:0]      cmd_btr,
  input  logic             cmd_btr_wr,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  output logic             busy,
  output logic             done,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  output logic             bus_rd,
  output logic             bus_wr,
  input  logic [31:0]      bus_rdata
`ifdef ARILLA_SEQ_RX_DRAIN_EN
  ,
  output logic             rx_valid,
  output logic [7:0]       rx_data
`endif
);

  // Gap counter runs 0 .. START_GAP-1
  localparam int GAP_W = (START_GAP > 2) ? $clog2(START_GAP) : 1;

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] chunk_q, chunk_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [4:0]       ctrl_q, ctrl_d;
  logic [31:0]      btr_q, btr_d;

  // Only a few CSR bits are consumed; the rest of the read word is ignored.
  logic unused_rdata;
  assign unused_rdata = ^bus_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      chunk_q <= '0;
      gap_q   <= '0;
      ctrl_q  <= '0;
      btr_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      chunk_q <= chunk_d;
      gap_q   <= gap_d;
      ctrl_q  <= ctrl_d;
      btr_q   <= btr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    chunk_d   = chunk_q;
    gap_d     = gap_q;
    ctrl_d    = ctrl_q;
    btr_d     = btr_q;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    tx_ready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ctrl_d  = cmd_ctrl;
          btr_d   = cmd_btr;
          rem_d   = cmd_len;
          chunk_d = '0;
          state_d = cmd_btr_wr ? ST_CFG_BTR : ST_CFG_CSR;
        end
      end

      ST_CFG_BTR: begin
        bus_wr    = 1'b1;
        bus_addr  = BASE_ADDR + BTR_OFS;
        bus_wdata = btr_q;
        state_d   = ST_CFG_CSR;
      end

      ST_CFG_CSR: begin
        bus_wr    = 1'b1;
        bus_addr  = BASE_ADDR + CSR_OFS;
        bus_wdata = csr_word(ctrl_q, 1'b0);
        state_d   = (rem_q == '0) ? ST_DONE : ST_POLL_SEND;
      end

      ST_POLL_SEND: begin
        bus_rd   = 1'b1;
        bus_addr = BASE_ADDR + CSR_OFS;
        // A full FIFO with nothing pushed yet this chunk cannot be ours to
        // flush, so keep polling instead of issuing an empty START.
        if (!bus_rdata[CSR_SEND_F]) begin
          state_d = ST_PUSH;
        end else if (chunk_q != '0) begin
          state_d = ST_START;
        end
      end

      ST_PUSH: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          bus_wr    = 1'b1;
          bus_addr  = BASE_ADDR + FIFO_OFS;
          bus_wdata = {24'd0, tx_data};
          rem_d     = rem_q - LEN_W'(1);
          chunk_d   = chunk_q + LEN_W'(1);
          state_d   = (rem_q == LEN_W'(1)) ? ST_START : ST_POLL_SEND;
        end
      end

      ST_START: begin
        bus_wr    = 1'b1;
        bus_addr  = BASE_ADDR + CSR_OFS;
        bus_wdata = csr_word(ctrl_q, 1'b1);
        chunk_d   = '0;
        gap_d     = '0;
        state_d   = (START_GAP == 0) ? ST_POLL_TIP : ST_GAP;
      end

      ST_GAP: begin
        if (gap_q == GAP_W'(START_GAP - 1)) begin
          state_d = ST_POLL_TIP;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      ST_POLL_TIP: begin
        bus_rd   = 1'b1;
        bus_addr = BASE_ADDR + CSR_OFS;
`ifdef ARILLA_SEQ_RX_DRAIN_EN
        // Pending receive data is drained before the transfer may complete.
        if (bus_rdata[CSR_RECV_NE]) begin
          state_d = ST_RX_READ;
        end else if (!bus_rdata[CSR_TRANS_IP]) begin
          state_d = (rem_q != '0) ? ST_POLL_SEND : ST_DONE;
        end
`else
        if (!bus_rdata[CSR_TRANS_IP]) begin
          state_d = (rem_q != '0) ? ST_POLL_SEND : ST_DONE;
        end
`endif
      end

`ifdef ARILLA_SEQ_RX_DRAIN_EN
      ST_RX_READ: begin
        bus_rd   = 1'b1;
        bus_addr = BASE_ADDR + FIFO_OFS;
        state_d  = ST_POLL_TIP;
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

`ifdef ARILLA_SEQ_RX_DRAIN_EN
  logic       rx_valid_q;
  logic [7:0] rx_data_q;

  // The FIFO byte is captured on the edge that ends the RX_READ cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= (state_q == ST_RX_READ);
      if (state_q == ST_RX_READ) begin
        rx_data_q <= bus_rdata[7:0];
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arilla_tx_sequencer.sv
// ============================================================================
//  Module      : tb_arilla_tx_sequencer
//  Description : Self-checking bench for arilla_tx_sequencer. A behavioural
//                transceiver model answers bus reads; expected bus writes and
//                receive bytes are queued when each command is issued and
//                compared as the DUT produces them.
//  Build option: ARILLA_SEQ_RX_DRAIN_EN enables the receive-drain scenario.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arilla_tx_sequencer;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_CSR  = BASE;
  localparam logic [31:0] A_BTR  = BASE + 32'd4;
  localparam logic [31:0] A_FIFO = BASE + 32'd8;
  localparam int          GAP    = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic [4:0]  cmd_ctrl;
  logic [31:0] cmd_btr;
  logic        cmd_btr_wr;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_rdata;
`ifdef ARILLA_SEQ_RX_DRAIN_EN
  logic        rx_valid;
  logic [7:0]  rx_data;
`endif

  arilla_tx_sequencer #(
    .BASE_ADDR (BASE),
    .LEN_W     (8),
    .START_GAP (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_ctrl   (cmd_ctrl),
    .cmd_btr    (cmd_btr),
    .cmd_btr_wr (cmd_btr_wr),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .busy       (busy),
    .done       (done),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rd     (bus_rd),
    .bus_wr     (bus_wr),
    .bus_rdata  (bus_rdata)
`ifdef ARILLA_SEQ_RX_DRAIN_EN
    ,
    .rx_valid   (rx_valid),
    .rx_data    (rx_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_csr(input logic [4:0] ctrl, input logic start);
    return {21'd0, ctrl[4:1], 1'b0, start, ctrl[0], 4'd0};
  endfunction

  // ---------------- scoreboard queues ----------------
  wr_t        exp_wr[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_rx[$];

  // ---------------- transceiver model ----------------
  int         fifo_cap  = 16;
  int         tip_len   = 10;
  int         fifo_cnt  = 0;
  int         tip_cnt   = 0;
  int         n_start   = 0;
  logic [7:0] rx_mem [0:7];
  int         rx_wr_cnt = 0;
  int         rx_rd_ptr = 0;

  always_comb begin
    bus_rdata = '0;
    if (bus_addr == A_FIFO) begin
      bus_rdata[7:0] = (rx_rd_ptr != rx_wr_cnt) ? rx_mem[rx_rd_ptr[2:0]] : 8'h00;
    end else begin
      bus_rdata[0] = (rx_rd_ptr != rx_wr_cnt);
      bus_rdata[2] = (fifo_cnt != 0);
      bus_rdata[3] = (fifo_cnt >= fifo_cap);
      bus_rdata[6] = (tip_cnt != 0);
    end
  end

  always @(posedge clk) begin
    if (tip_cnt != 0) tip_cnt <= tip_cnt - 1;
    if (!rst && bus_wr) begin
      if (bus_addr == A_FIFO) begin
        fifo_cnt <= fifo_cnt + 1;
      end else if (bus_addr == A_CSR && bus_wdata[5]) begin
        fifo_cnt <= 0;
        tip_cnt  <= tip_len;
        n_start  <= n_start + 1;
      end
    end
    if (!rst && bus_rd && bus_addr == A_FIFO && rx_rd_ptr != rx_wr_cnt) begin
      rx_rd_ptr <= rx_rd_ptr + 1;
    end
  end

  // ---------------- byte source with optional stall ----------------
  int stall_cycles = 0;
  int stall_gen    = 0;

  initial begin
    int stall_cnt;
    int seen_gen;
    stall_cnt = 0;
    seen_gen  = 0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    forever begin
      @(negedge clk);
      if (seen_gen != stall_gen && tx_ready) begin
        seen_gen  = stall_gen;
        stall_cnt = stall_cycles;
      end
      if (stall_cnt > 0) begin
        tx_valid = 1'b0;
        #1;
        check_eq("stall_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("stall_bus_rd", {31'd0, bus_rd}, 32'd0);
        check_eq("stall_bus_wr", {31'd0, bus_wr}, 32'd0);
        check_eq("stall_bus_addr", bus_addr, 32'd0);
        stall_cnt--;
      end else begin
        tx_valid = (tx_q.size() > 0);
        tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        #1;
        if (tx_valid && tx_ready && !rst) void'(tx_q.pop_front());
      end
    end
  end

  // ---------------- bus monitor ----------------
  initial begin
    wr_t w;
    logic ok;
    int   since_start;
    bit   armed;
    armed       = 1'b0;
    since_start = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        armed = 1'b0;
      end else begin
        if (bus_wr) begin
          check_eq("rd_wr_excl", {31'd0, bus_rd}, 32'd0);
          check_eq("wr_pending", {31'd0, exp_wr.size() != 0}, 32'd1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            check_eq("wr_addr", bus_addr, w.addr);
            check_eq("wr_data", bus_wdata, w.data);
          end
        end
        if (armed) since_start++;
        if (bus_wr && bus_addr == A_CSR && bus_wdata[5]) begin
          armed       = 1'b1;
          since_start = 0;
        end
        if (bus_rd) begin
`ifdef ARILLA_SEQ_RX_DRAIN_EN
          ok = (bus_addr == A_CSR) || (bus_addr == A_FIFO);
`else
          ok = (bus_addr == A_CSR);
`endif
          check_eq("rd_addr_legal", {31'd0, ok}, 32'd1);
          if (armed) begin
            check_eq("start_to_poll", since_start, GAP + 1);
            armed = 1'b0;
          end
        end
`ifdef ARILLA_SEQ_RX_DRAIN_EN
        if (rx_valid) begin
          check_eq("rx_pending", {31'd0, exp_rx.size() != 0}, 32'd1);
          if (exp_rx.size() != 0) check_eq("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
        end
`endif
      end
    end
  end

  // ---------------- command driver ----------------
  task automatic run_cmd(input int len, input logic [4:0] ctrl, input logic btr_wr,
                         input logic [31:0] btr, input int cap, input int tlen,
                         input int stall, input bit wait_done);
    int         rem;
    int         n;
    int         k;
    int         nstart;
    int         start_before;
    int         budget;
    logic [7:0] b;
    fifo_cap = cap;
    tip_len  = tlen;
    if (stall > 0) begin
      stall_cycles = stall;
      stall_gen++;
    end
    if (btr_wr) exp_wr.push_back('{addr: A_BTR, data: btr});
    exp_wr.push_back('{addr: A_CSR, data: exp_csr(ctrl, 1'b0)});
    rem    = len;
    k      = 0;
    nstart = 0;
    while (rem > 0) begin
      n = (rem < cap) ? rem : cap;
      for (int i = 0; i < n; i++) begin
        b = 8'((k + 1) * 17);
        exp_wr.push_back('{addr: A_FIFO, data: {24'd0, b}});
        tx_q.push_back(b);
        k++;
      end
      rem -= n;
      exp_wr.push_back('{addr: A_CSR, data: exp_csr(ctrl, 1'b1)});
      nstart++;
    end
    start_before = n_start;

    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_len    = 8'(len);
    cmd_ctrl   = ctrl;
    cmd_btr    = btr;
    cmd_btr_wr = btr_wr;
    budget     = 0;
    #1;
    while (!cmd_ready && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check_eq("cmd_ready_seen", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
    check_eq("first_access_wr", {31'd0, bus_wr}, 32'd1);

    if (wait_done) begin
      budget = 0;
      while (!done && budget < 2000) begin
        @(negedge clk);
        #1;
        budget++;
      end
      check_eq("done_seen", {31'd0, done}, 32'd1);
      @(negedge clk);
      #1;
      check_eq("done_one_cycle", {31'd0, done}, 32'd0);
      check_eq("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("idle_busy", {31'd0, busy}, 32'd0);
      check_eq("writes_left", exp_wr.size(), 32'd0);
      check_eq("start_count", n_start - start_before, nstart);
      check_eq("tx_left", tx_q.size(), 32'd0);
      check_eq("rx_left", exp_rx.size(), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_bus_rd"}, {31'd0, bus_rd}, 32'd0);
    check_eq({tag, "_bus_wr"}, {31'd0, bus_wr}, 32'd0);
    check_eq({tag, "_bus_addr"}, bus_addr, 32'd0);
    check_eq({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    check_eq({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd0);
`ifdef ARILLA_SEQ_RX_DRAIN_EN
    check_eq({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    int start_before;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_len    = 8'd0;
    cmd_ctrl   = 5'd0;
    cmd_btr    = 32'd0;
    cmd_btr_wr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_reset_outputs("post_rst");

    // three bytes, FIFO never full, long transfer
    run_cmd(3, 5'b10101, 1'b0, 32'd0, 16, 10, 0, 1'b1);
    // FIFO capacity 4 splits five bytes into 4 + 1
    run_cmd(5, 5'b01010, 1'b0, 32'd0, 4, 6, 0, 1'b1);
    // bit time reload with zero length
    run_cmd(0, 5'b00001, 1'b1, 32'h0000_0064, 16, 10, 0, 1'b1);
    // byte source stalls five cycles inside PUSH
    run_cmd(2, 5'b11111, 1'b0, 32'd0, 16, 3, 5, 1'b1);

    // reset while polling TRANS_IP
    start_before = n_start;
    run_cmd(2, 5'b00100, 1'b0, 32'd0, 16, 20, 0, 1'b0);
    budget = 0;
    while (n_start == start_before && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check_eq("mid_start_seen", {31'd0, n_start != start_before}, 32'd1);
    repeat (GAP) @(negedge clk);
    #1;
    check_eq("pre_rst_poll_rd", {31'd0, bus_rd}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    check_eq("mid_rst_writes_left", exp_wr.size(), 32'd0);
    check_reset_outputs("mid_rst_idle");

    // normal command after the abandoned one
    run_cmd(1, 5'b00010, 1'b0, 32'd0, 16, 4, 0, 1'b1);

`ifdef ARILLA_SEQ_RX_DRAIN_EN
    rx_mem[rx_wr_cnt[2:0]] = 8'hA5;
    rx_wr_cnt              = rx_wr_cnt + 1;
    rx_mem[rx_wr_cnt[2:0]] = 8'h5A;
    rx_wr_cnt              = rx_wr_cnt + 1;
    exp_rx.push_back(8'hA5);
    exp_rx.push_back(8'h5A);
    run_cmd(1, 5'b00001, 1'b0, 32'd0, 16, 4, 0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
